// File: rtl/konane_pkg.sv
// Shared definitions for the Konane auto player.
// Board geometry, initial position and coordinate helpers.
package konane_pkg;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    localparam int BOARD_W = 6;
    localparam int CELLS   = 36;

    localparam logic [CELLS-1:0] INIT_OCCUPIED         = 36'hFFFFF3FFF;
    localparam logic [CELLS-1:0] INIT_BLACK_SELECTABLE = 36'h004001004;

    localparam logic signed [4:0] GIVEUP_COORD = -5'sd1;

    typedef enum logic [1:0] {
        S_DECIDE,
        S_ISSUE,
        S_HOST,
        S_WAIT
    } state_t;

    // Callers only pass on-board coordinates.
    function automatic logic [5:0] idx_of(input logic [4:0] i, input logic [4:0] j);
        logic [7:0] t;
        t = 8'(i) * 8'(BOARD_W) + 8'(j);
        return t[5:0];
    endfunction

    function automatic logic [4:0] row_of(input logic [5:0] idx);
        return 5'(idx / 6'd6);
    endfunction

    function automatic logic [4:0] col_of(input logic [5:0] idx);
        return 5'(idx % 6'd6);
    endfunction

endpackage

// File: rtl/konane_rr_pick.sv
// Rotating priority encoder: first set bit of mask at index >= start,
// wrapping around the 36 cells.
module konane_rr_pick
    import konane_pkg::*;
(
    input  logic [CELLS-1:0] mask_i,
    input  logic [5:0]       start_i,
    output logic             found_o,
    output logic [5:0]       idx_o
);

    logic [6:0] c;

    // Scan from the far end so the nearest hit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        c       = '0;
        for (int k = CELLS - 1; k >= 0; k--) begin
            c = 7'(start_i) + 7'(k);
            if (c >= 7'(CELLS)) c = c - 7'(CELLS);
            if (mask_i[c[5:0]]) begin
                found_o = 1'b1;
                idx_o   = c[5:0];
            end
        end
    end

endmodule

// File: rtl/konane_auto_player.sv
// Drives the Konane controller op channel from an internal picker or the
// host, mirrors board occupancy and republishes results as events.
module konane_auto_player
    import konane_pkg::*;
#(
    parameter bit AUTO_BLACK      = 1'b1,
    parameter bit AUTO_WHITE      = 1'b0,
    parameter bit GIVEUP_ON_CHAIN = 1'b0,
    parameter int PTR_STEP        = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [4:0]       op_i,
    output logic [4:0]       op_j,
    output logic             re_ready,
    input  logic             re_valid,
    input  logic             re_is_finished,
    input  logic             re_next_player_id,
    input  logic             re_player_can_giveup,
    input  logic [CELLS-1:0] re_selectable,
    input  logic             host_op_valid,
    output logic             host_op_ready,
    input  logic [4:0]       host_op_i,
    input  logic [4:0]       host_op_j,
    output logic             evt_valid,
    output logic             evt_player,
    output logic             evt_finished,
    output logic [CELLS-1:0] evt_selectable,
    output logic             stuck
);

    state_t           state_q, state_d;
    logic [CELLS-1:0] mirror_q, mirror_d;
    logic [CELLS-1:0] sel_q, sel_d;
    logic             mover_q, mover_d;
    logic             cangu_q, cangu_d;
    logic [5:0]       src_q, src_d;
    logic [5:0]       ptr_q, ptr_d;
    logic [4:0]       pick_i_q, pick_i_d;
    logic [4:0]       pick_j_q, pick_j_d;
    logic             stuck_q, stuck_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_player_q, evt_player_d;
    logic             evt_finished_q, evt_finished_d;
    logic [CELLS-1:0] evt_sel_q, evt_sel_d;

    logic [CELLS-1:0] targets, stones;
    logic             tgt_found, stn_found;
    logic [5:0]       tgt_idx, stn_idx, pick_idx;
    logic             auto_turn;
    logic             op_fire, on_board;
    logic [5:0]       dst, mid;
    logic [4:0]       src_r, src_c, mid_r, mid_c;
    logic [6:0]       ptr_sum;
    logic [5:0]       ptr_adv;

    assign targets = sel_q & ~mirror_q;
    assign stones  = sel_q & mirror_q;

    konane_rr_pick u_tgt (
        .mask_i  (targets),
        .start_i (ptr_q),
        .found_o (tgt_found),
        .idx_o   (tgt_idx)
    );

    konane_rr_pick u_stn (
        .mask_i  (stones),
        .start_i (ptr_q),
        .found_o (stn_found),
        .idx_o   (stn_idx)
    );

    assign pick_idx  = tgt_found ? tgt_idx : stn_idx;
    assign auto_turn = (mover_q == WHITE) ? AUTO_WHITE : AUTO_BLACK;

    assign ptr_sum = 7'(ptr_q) + 7'(PTR_STEP % CELLS);
    assign ptr_adv = (ptr_sum >= 7'(CELLS)) ? 6'(ptr_sum - 7'(CELLS))
                                            : ptr_sum[5:0];

    always_comb begin
        op_valid      = 1'b0;
        host_op_ready = 1'b0;
        op_i          = pick_i_q;
        op_j          = pick_j_q;
        if (state_q == S_ISSUE) begin
            op_valid = 1'b1;
        end else if (state_q == S_HOST) begin
            op_valid      = host_op_valid;
            host_op_ready = op_ready;
            op_i          = host_op_i;
            op_j          = host_op_j;
        end
    end

    assign re_ready = (state_q == S_WAIT);
    assign op_fire  = op_valid & op_ready;

    // Negative or off-board coordinates leave the mirror untouched.
    assign on_board = !op_i[4] && !op_j[4] && op_i < 5'd6 && op_j < 5'd6;
    assign dst      = idx_of(op_i, op_j);
    assign src_r    = row_of(src_q);
    assign src_c    = col_of(src_q);
    assign mid_r    = (src_r + op_i) >> 1;
    assign mid_c    = (src_c + op_j) >> 1;
    assign mid      = idx_of(mid_r, mid_c);

    always_comb begin
        state_d        = state_q;
        mirror_d       = mirror_q;
        sel_d          = sel_q;
        mover_d        = mover_q;
        cangu_d        = cangu_q;
        src_d          = src_q;
        ptr_d          = ptr_q;
        pick_i_d       = pick_i_q;
        pick_j_d       = pick_j_q;
        stuck_d        = stuck_q;
        evt_valid_d    = 1'b0;
        evt_player_d   = evt_player_q;
        evt_finished_d = evt_finished_q;
        evt_sel_d      = evt_sel_q;

        unique case (state_q)
            S_DECIDE: begin
                if (!auto_turn) begin
                    state_d = S_HOST;
                end else if ((cangu_q && GIVEUP_ON_CHAIN) ||
                             (cangu_q && !tgt_found && !stn_found)) begin
                    pick_i_d = GIVEUP_COORD;
                    pick_j_d = GIVEUP_COORD;
                    state_d  = S_ISSUE;
                end else if (tgt_found || stn_found) begin
                    pick_i_d = row_of(pick_idx);
                    pick_j_d = col_of(pick_idx);
                    state_d  = S_ISSUE;
                end else begin
                    stuck_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    state_d = S_WAIT;
                    ptr_d   = ptr_adv;
                end
            end
            S_HOST: begin
                if (op_fire) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (re_valid) begin
                    sel_d          = re_selectable;
                    mover_d        = re_next_player_id;
                    cangu_d        = re_player_can_giveup;
                    evt_valid_d    = 1'b1;
                    evt_player_d   = re_next_player_id;
                    evt_finished_d = re_is_finished;
                    evt_sel_d      = re_selectable;
                    state_d        = S_DECIDE;
                    if (re_is_finished) begin
                        mirror_d = INIT_OCCUPIED;
                        sel_d    = INIT_BLACK_SELECTABLE;
                        ptr_d    = '0;
                        mover_d  = BLACK;
                    end
                end
            end
            default: state_d = S_DECIDE;
        endcase

        // A move onto an empty cell completes a jump from the last pick.
        if (op_fire && on_board) begin
            if (!mirror_q[dst]) begin
                mirror_d[src_q] = 1'b0;
                mirror_d[mid]   = 1'b0;
                mirror_d[dst]   = 1'b1;
            end
            src_d = dst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_DECIDE;
            mirror_q       <= INIT_OCCUPIED;
            sel_q          <= INIT_BLACK_SELECTABLE;
            mover_q        <= BLACK;
            cangu_q        <= 1'b0;
            src_q          <= '0;
            ptr_q          <= '0;
            pick_i_q       <= '0;
            pick_j_q       <= '0;
            stuck_q        <= 1'b0;
            evt_valid_q    <= 1'b0;
            evt_player_q   <= 1'b0;
            evt_finished_q <= 1'b0;
            evt_sel_q      <= '0;
        end else begin
            state_q        <= state_d;
            mirror_q       <= mirror_d;
            sel_q          <= sel_d;
            mover_q        <= mover_d;
            cangu_q        <= cangu_d;
            src_q          <= src_d;
            ptr_q          <= ptr_d;
            pick_i_q       <= pick_i_d;
            pick_j_q       <= pick_j_d;
            stuck_q        <= stuck_d;
            evt_valid_q    <= evt_valid_d;
            evt_player_q   <= evt_player_d;
            evt_finished_q <= evt_finished_d;
            evt_sel_q      <= evt_sel_d;
        end
    end

    assign evt_valid      = evt_valid_q;
    assign evt_player     = evt_player_q;
    assign evt_finished   = evt_finished_q;
    assign evt_selectable = evt_sel_q;
    assign stuck          = stuck_q;

endmodule

// File: tb/tb_konane_auto_player.sv
// Self-checking bench for konane_auto_player: directed scenarios plus a
// randomized game against a board-level reference model.
module tb_konane_auto_player;

    logic        clk;
    logic        rst_n;
    logic        op_ready;
    logic        re_valid;
    logic        re_is_finished;
    logic        re_next_player_id;
    logic        re_player_can_giveup;
    logic [35:0] re_selectable;
    logic        host_op_valid;
    logic [4:0]  host_op_i;
    logic [4:0]  host_op_j;

    logic        op_valid, re_ready, host_op_ready;
    logic [4:0]  op_i, op_j;
    logic        evt_valid, evt_player, evt_finished, stuck;
    logic [35:0] evt_selectable;

    logic        g_op_valid, g_re_ready, g_host_op_ready;
    logic [4:0]  g_op_i, g_op_j;
    logic        g_evt_valid, g_evt_player, g_evt_finished, g_stuck;
    logic [35:0] g_evt_selectable;

    int n_checks = 0;
    int n_pass   = 0;

    konane_auto_player u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .op_valid             (op_valid),
        .op_ready             (op_ready),
        .op_i                 (op_i),
        .op_j                 (op_j),
        .re_ready             (re_ready),
        .re_valid             (re_valid),
        .re_is_finished       (re_is_finished),
        .re_next_player_id    (re_next_player_id),
        .re_player_can_giveup (re_player_can_giveup),
        .re_selectable        (re_selectable),
        .host_op_valid        (host_op_valid),
        .host_op_ready        (host_op_ready),
        .host_op_i            (host_op_i),
        .host_op_j            (host_op_j),
        .evt_valid            (evt_valid),
        .evt_player           (evt_player),
        .evt_finished         (evt_finished),
        .evt_selectable       (evt_selectable),
        .stuck                (stuck)
    );

    konane_auto_player #(.GIVEUP_ON_CHAIN(1'b1)) u_gu (
        .clk                  (clk),
        .rst_n                (rst_n),
        .op_valid             (g_op_valid),
        .op_ready             (op_ready),
        .op_i                 (g_op_i),
        .op_j                 (g_op_j),
        .re_ready             (g_re_ready),
        .re_valid             (re_valid),
        .re_is_finished       (re_is_finished),
        .re_next_player_id    (re_next_player_id),
        .re_player_can_giveup (re_player_can_giveup),
        .re_selectable        (re_selectable),
        .host_op_valid        (host_op_valid),
        .host_op_ready        (g_host_op_ready),
        .host_op_i            (host_op_i),
        .host_op_j            (host_op_j),
        .evt_valid            (g_evt_valid),
        .evt_player           (g_evt_player),
        .evt_finished         (g_evt_finished),
        .evt_selectable       (g_evt_selectable),
        .stuck                (g_stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the board as the main DUT should see it.
    bit [35:0] m_occ, m_sel;
    int        m_ptr, m_src;
    bit        m_mover, m_cg;

    function automatic void m_init();
        m_occ     = '1;
        m_occ[14] = 1'b0;
        m_occ[15] = 1'b0;
        m_sel     = '0;
        m_sel[2]  = 1'b1;
        m_sel[12] = 1'b1;
        m_sel[26] = 1'b1;
        m_ptr     = 0;
        m_src     = 0;
        m_mover   = 1'b0;
        m_cg      = 1'b0;
    endfunction

    // Returns a cell index, -1 for give-up, -2 for no legal choice.
    function automatic int m_pick(input bit gu);
        bit [35:0] t, s;
        t = m_sel & ~m_occ;
        s = m_sel & m_occ;
        if (m_cg && gu) return -1;
        for (int k = 0; k < 36; k++)
            if (t[(m_ptr + k) % 36]) return (m_ptr + k) % 36;
        for (int k = 0; k < 36; k++)
            if (s[(m_ptr + k) % 36]) return (m_ptr + k) % 36;
        if (m_cg) return -1;
        return -2;
    endfunction

    function automatic void m_fire(input int i, input int j, input bit auto_mv);
        int d, mr, mc;
        if (i >= 0 && j >= 0 && i < 6 && j < 6) begin
            d = i * 6 + j;
            if (!m_occ[d]) begin
                mr = (m_src / 6 + i) / 2;
                mc = (m_src % 6 + j) / 2;
                m_occ[m_src]     = 1'b0;
                m_occ[mr * 6 + mc] = 1'b0;
                m_occ[d]         = 1'b1;
            end
            m_src = d;
        end
        if (auto_mv) m_ptr = (m_ptr + 7) % 36;
    endfunction

    function automatic void m_result(input bit [35:0] s, input bit pl,
                                     input bit cg, input bit fin);
        m_sel   = s;
        m_mover = pl;
        m_cg    = cg;
        if (fin) begin
            m_occ     = '1;
            m_occ[14] = 1'b0;
            m_occ[15] = 1'b0;
            m_sel     = 36'h004001004;
            m_ptr     = 0;
            m_mover   = 1'b0;
        end
    endfunction

    // All stimulus tasks start and end on a falling edge.
    task automatic apply_reset();
        rst_n         = 1'b0;
        op_ready      = 1'b0;
        re_valid      = 1'b0;
        host_op_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        m_init();
    endtask

    task automatic wait_op(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (op_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_re(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (re_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic fire_op();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic test_auto_move(input string nm, input int ei, input int ej,
                                  input bit gchk, input int gi, input int gj);
        bit ok;
        wait_op(ok);
        n_checks++;
        if (!ok) $display("FAIL %s timeout: op_valid=%0b required 1", nm, op_valid);
        else n_pass++;
        if (ok) begin
            n_checks++;
            if (int'($signed(op_i)) !== ei || int'($signed(op_j)) !== ej)
                $display("FAIL %s op: got (%0d,%0d) required (%0d,%0d)", nm,
                         $signed(op_i), $signed(op_j), ei, ej);
            else n_pass++;
            if (gchk) begin
                n_checks++;
                if (g_op_valid !== 1'b1 || int'($signed(g_op_i)) !== gi ||
                    int'($signed(g_op_j)) !== gj)
                    $display("FAIL %s giveup-dut op: got v=%0b (%0d,%0d) required (%0d,%0d)",
                             nm, g_op_valid, $signed(g_op_i), $signed(g_op_j), gi, gj);
                else n_pass++;
            end
            fire_op();
        end
        m_fire(ei, ej, 1'b1);
    endtask

    task automatic test_result(input string nm, input bit [35:0] s, input bit pl,
                               input bit cg, input bit fin);
        bit ok;
        wait_re(ok);
        n_checks++;
        if (!ok) $display("FAIL %s re timeout: re_ready=%0b required 1", nm, re_ready);
        else n_pass++;
        if (ok) begin
            re_valid             = 1'b1;
            re_selectable        = s;
            re_next_player_id    = pl;
            re_player_can_giveup = cg;
            re_is_finished       = fin;
            @(negedge clk);
            re_valid = 1'b0;
            n_checks++;
            if ({evt_valid, evt_player, evt_finished, evt_selectable} !==
                {1'b1, pl, fin, s})
                $display("FAIL %s evt: got v=%0b p=%0b f=%0b s=%h required v=1 p=%0b f=%0b s=%h",
                         nm, evt_valid, evt_player, evt_finished, evt_selectable,
                         pl, fin, s);
            else n_pass++;
        end
        m_result(s, pl, cg, fin);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({op_valid, op_i, op_j, re_ready, host_op_ready} !== 13'd0)
            $display("FAIL reset_op: got v=%0b i=%0d j=%0d rr=%0b hr=%0b required all 0",
                     op_valid, op_i, op_j, re_ready, host_op_ready);
        else n_pass++;
        n_checks++;
        if ({evt_valid, evt_player, evt_finished, evt_selectable, stuck} !== 40'd0)
            $display("FAIL reset_evt: got v=%0b p=%0b f=%0b s=%h st=%0b required all 0",
                     evt_valid, evt_player, evt_finished, evt_selectable, stuck);
        else n_pass++;
        release_reset();
    endtask

    task automatic test_hold_first();
        bit ok;
        host_op_valid = 1'b1;
        host_op_i     = 5'd1;
        host_op_j     = 5'd1;
        wait_op(ok);
        n_checks++;
        if (!ok || op_i !== 5'd0 || op_j !== 5'd2)
            $display("FAIL first_op: got v=%0b (%0d,%0d) required (0,2)", op_valid, op_i, op_j);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({op_valid, op_i, op_j, host_op_ready} !== {1'b1, 5'd0, 5'd2, 1'b0})
                $display("FAIL hold_stable: got v=%0b (%0d,%0d) hr=%0b required v=1 (0,2) hr=0",
                         op_valid, op_i, op_j, host_op_ready);
            else n_pass++;
        end
        op_ready = 1'b1;
        #1;
        n_checks++;
        if (host_op_ready !== 1'b0)
            $display("FAIL host_ready_auto: got %0b required 0", host_op_ready);
        else n_pass++;
        @(negedge clk);
        op_ready      = 1'b0;
        host_op_valid = 1'b0;
        m_fire(0, 2, 1'b1);
        n_checks++;
        if (op_valid !== 1'b0 || re_ready !== 1'b1)
            $display("FAIL single_fire: got v=%0b rr=%0b required v=0 rr=1", op_valid, re_ready);
        else n_pass++;
    endtask

    task automatic test_jump_and_ptr();
        test_result("jump_re", 36'h1 << 14, 1'b0, 1'b0, 1'b0);
        test_auto_move("jump_op", 2, 2, 1'b0, 0, 0);
        test_result("mirror_re", (36'h1 << 2) | (36'h1 << 8) | (36'h1 << 14),
                    1'b0, 1'b0, 1'b0);
        test_auto_move("mirror_op", 0, 2, 1'b0, 0, 0);
        test_result("ptr_re", (36'h1 << 22) | (36'h1 << 28), 1'b0, 1'b0, 1'b0);
        test_auto_move("ptr_op", 3, 4, 1'b0, 0, 0);
    endtask

    task automatic test_host();
        bit ok;
        test_result("host_re", 36'h1 << 3, 1'b1, 1'b0, 1'b0);
        host_op_valid = 1'b1;
        host_op_i     = 5'd0;
        host_op_j     = 5'd3;
        wait_op(ok);
        n_checks++;
        if (!ok || op_i !== 5'd0 || op_j !== 5'd3 || host_op_ready !== 1'b0)
            $display("FAIL host_fwd: got v=%0b (%0d,%0d) hr=%0b required v=1 (0,3) hr=0",
                     op_valid, op_i, op_j, host_op_ready);
        else n_pass++;
        op_ready = 1'b1;
        #1;
        n_checks++;
        if (host_op_ready !== 1'b1)
            $display("FAIL host_ready: got %0b required 1", host_op_ready);
        else n_pass++;
        @(negedge clk);
        op_ready      = 1'b0;
        host_op_valid = 1'b0;
        m_fire(0, 3, 1'b0);
        n_checks++;
        if (re_ready !== 1'b1 || op_valid !== 1'b0)
            $display("FAIL host_wait: got rr=%0b v=%0b required rr=1 v=0", re_ready, op_valid);
        else n_pass++;
    endtask

    task automatic test_giveup();
        apply_reset();
        release_reset();
        test_auto_move("gu_first", 0, 2, 1'b1, 0, 2);
        test_result("gu_re", 36'h1 << 26, 1'b0, 1'b1, 1'b0);
        test_auto_move("gu_chain", 4, 2, 1'b1, -1, -1);
        test_result("gu_re2", 36'h1 << 2, 1'b0, 1'b0, 1'b0);
        test_auto_move("gu_after", 0, 2, 1'b1, 0, 2);
    endtask

    task automatic test_finished();
        bit [35:0] s;
        s = {4'($urandom), $urandom};
        test_result("fin_re", s, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b0)
            $display("FAIL fin_pulse: evt_valid got %0b required 0", evt_valid);
        else n_pass++;
        test_auto_move("fin_next", 0, 2, 1'b0, 0, 0);
    endtask

    task automatic test_stuck_and_reset();
        int seen;
        test_result("stuck_re", 36'h0, 1'b0, 1'b0, 1'b0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (op_valid) seen++;
        end
        n_checks++;
        if (stuck !== 1'b1 || seen != 0)
            $display("FAIL stuck: got stuck=%0b op_cycles=%0d required stuck=1 op_cycles=0",
                     stuck, seen);
        else n_pass++;
        apply_reset();
        release_reset();
        test_auto_move("rst_first", 0, 2, 1'b0, 0, 0);
        n_checks++;
        if (re_ready !== 1'b1 || stuck !== 1'b0)
            $display("FAIL rst_wait: got rr=%0b stuck=%0b required rr=1 stuck=0", re_ready, stuck);
        else n_pass++;
        re_valid          = 1'b1;
        re_selectable     = '1;
        re_next_player_id = 1'b1;
        rst_n             = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({op_valid, op_i, op_j, re_ready, host_op_ready, evt_valid, evt_player,
             evt_finished, evt_selectable, stuck} !== 53'd0)
            $display("FAIL rst_mid_wait: got v=%0b rr=%0b ev=%0b s=%h st=%0b required all 0",
                     op_valid, re_ready, evt_valid, evt_selectable, stuck);
        else n_pass++;
        re_valid = 1'b0;
        @(negedge clk);
        release_reset();
    endtask

    task automatic test_random();
        bit        ok;
        bit [63:0] r64;
        bit [35:0] s;
        int        e, hi, hj;
        for (int t = 0; t < 60; t++) begin
            if (!m_mover) begin
                e = m_pick(1'b0);
                if (e < 0) test_auto_move("rnd_auto", -1, -1, 1'b0, 0, 0);
                else test_auto_move("rnd_auto", e / 6, e % 6, 1'b0, 0, 0);
            end else begin
                if ($urandom_range(7) == 0) begin
                    hi = -1;
                    hj = -1;
                end else begin
                    hi = int'($urandom_range(5));
                    hj = int'($urandom_range(5));
                end
                host_op_valid = 1'b1;
                host_op_i     = 5'(hi);
                host_op_j     = 5'(hj);
                wait_op(ok);
                n_checks++;
                if (!ok || int'($signed(op_i)) !== hi || int'($signed(op_j)) !== hj ||
                    host_op_ready !== 1'b0)
                    $display("FAIL rnd_host: got v=%0b (%0d,%0d) hr=%0b required (%0d,%0d) hr=0",
                             op_valid, $signed(op_i), $signed(op_j), host_op_ready, hi, hj);
                else n_pass++;
                if (ok) fire_op();
                host_op_valid = 1'b0;
                m_fire(hi, hj, 1'b0);
            end
            r64 = {$urandom, $urandom};
            s   = r64[35:0];
            s[$urandom_range(35)] = 1'b1;
            test_result("rnd_re", s, 1'($urandom_range(1)),
                        $urandom_range(3) == 0, $urandom_range(11) == 0);
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        op_ready             = 1'b0;
        re_valid             = 1'b0;
        re_is_finished       = 1'b0;
        re_next_player_id    = 1'b0;
        re_player_can_giveup = 1'b0;
        re_selectable        = '0;
        host_op_valid        = 1'b0;
        host_op_i            = '0;
        host_op_j            = '0;
        m_init();
        @(negedge clk);
        test_reset();
        test_hold_first();
        test_jump_and_ptr();
        test_host();
        test_giveup();
        test_finished();
        test_stuck_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/konane_auto_player.md
Name: konane_auto_player

Overview:
- Upstream/downstream companion of the Konane game controller. Drives its op channel (op_valid/op_ready/op_i/op_j) and consumes its result channel (re_*).
- For each colour, a parameter selects the driver:
  - automated: a built-in move picker chooses the move;
  - host: moves are forwarded from a host op channel.
- Keeps a 36-bit occupancy mirror so it can tell stone picks from jump targets.
- Republishes every controller result to the host as a one-cycle event.

Parameters:
- AUTO_BLACK, 1, black moves chosen by the internal picker when 1, forwarded from the host when 0.
- AUTO_WHITE, 0, same selection for white.
- GIVEUP_ON_CHAIN, 0, when 1 the picker declines every multi-jump continuation (sends -1,-1).
- PTR_STEP, 7, amount added to the rotating pick pointer (mod 36) after each automated op fire.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- op_valid  out  1  op request to controller
- op_ready  in  1  controller accepts op
- op_i  out  5  signed row; -1 = give up chain
- op_j  out  5  signed col; -1 = give up chain
- re_ready  out  1  ready for controller result
- re_valid  in  1  controller result valid
- re_is_finished  in  1  game over flag
- re_next_player_id  in  1  0 black, 1 white
- re_player_can_giveup  in  1  chain continuation pending
- re_selectable  in  36  legal positions, idx = i*6+j
- host_op_valid  in  1  host move valid
- host_op_ready  out  1  host move accepted
- host_op_i  in  5  host row
- host_op_j  in  5  host col
- evt_valid  out  1  one-cycle result event, no backpressure
- evt_player  out  1  registered re_next_player_id
- evt_finished  out  1  registered re_is_finished
- evt_selectable  out  36  registered re_selectable
- stuck  out  1  sticky: automated turn with empty selectable and no give-up allowed

Behaviour:
- Reset: clk is the single clock. rst_n is synchronous and active-low.
- Reset values: every output is 0 except op_i/op_j (0).
  - mirror = all ones except idx 14, 15.
  - sel = 36'h004001004 (black movable at start: 2, 12, 26).
  - mover = black, can_giveup = 0, src = 0, ptr = 0, state S_DECIDE.
- Reset is honoured in any state. Any in-flight op/result is abandoned.
- S_DECIDE (1 cycle):
  - If the mover is automated, register a pick and go to S_ISSUE; otherwise go to S_HOST.
  - Pick rules:
    - targets = sel & ~mirror; stones = sel & mirror.
    - If can_giveup and GIVEUP_ON_CHAIN: pick give-up.
    - Else if targets != 0: first set bit of targets at index >= ptr, wrapping.
    - Else if stones != 0: the same search applied to stones.
    - Else if can_giveup: give-up.
    - Else: set stuck and stay in S_DECIDE.
  - Index-to-coordinates: i = idx/6, j = idx%6.
- S_ISSUE: op_valid = 1, op_i/op_j held stable until op_ready. On fire, go to S_WAIT and advance ptr = (ptr + PTR_STEP) mod 36.
- S_HOST:
  - op_valid = host_op_valid; host_op_ready = op_ready; op_i/op_j = host_op_i/host_op_j (combinational pass-through).
  - On fire, go to S_WAIT. host_op_ready is 0 in every other state.
- Bookkeeping on any op fire (idx = i*6+j):
  - Give-up (i < 0 or j < 0): no mirror change.
  - mirror[idx] = 1: src = idx.
  - mirror[idx] = 0: clear mirror[src]; clear mirror[midpoint of src and idx]; set mirror[idx]; src = idx.
- S_WAIT:
  - re_ready = 1. On re fire, register sel, mover = re_next_player_id, can_giveup = re_player_can_giveup.
  - Pulse evt_valid the next cycle with the registered fields.
  - If re_is_finished: mirror, sel and ptr return to reset values; mover = black.
  - Go to S_DECIDE.
- re_ready is 0 outside S_WAIT. op_valid is 0 outside S_ISSUE/S_HOST. Exactly one outstanding op at a time.
- A result arriving outside S_WAIT is not accepted and waits under the controller's handshake.

Decomposition:
- Shared package konane_pkg holds:
  - BLACK/WHITE ids;
  - BOARD_W = 6, CELLS = 36;
  - INIT_OCCUPIED;
  - INIT_BLACK_SELECTABLE;
  - GIVEUP_COORD = -1;
  - idx/coordinate conversion functions.
- One sub-module, konane_rr_pick: 36-bit mask plus 6-bit start pointer in, found flag plus 6-bit index out. Purely combinational rotating priority encoder, registered by the parent.

Test Plan:
- Reset, AUTO_BLACK=1 -> first op is (0,2) after S_DECIDE. A result with selectable bit 14 set -> next op (2,2); mirror bits 2 and 8 cleared, bit 14 set.
- Hold op_ready=0 for 5 cycles during S_ISSUE -> op_valid, op_i and op_j stay constant; a single fire; ptr advances by exactly 7.
- White turn with AUTO_WHITE=0: host sends (0,3) -> forwarded unchanged, host_op_ready mirrors op_ready. Host traffic during a black auto turn -> host_op_ready stays 0.
- Result with can_giveup=1 and selectable = {26}, GIVEUP_ON_CHAIN=1 -> op (-1,-1), mirror unchanged. With GIVEUP_ON_CHAIN=0 -> op (4,2).
- Result with re_is_finished=1 -> evt_finished=1 for one cycle. Mirror and sel return to reset values and the next op is (0,2).
- Automated turn with selectable=0 and can_giveup=0 -> stuck=1, no op_valid. Reset mid-S_WAIT -> all outputs return to reset values on the next edge.
